// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and constants for serial_to_parallel_register
//
// Purpose : FSM state encoding, bit-order codes and reset values shared by
//           serial_to_parallel_register and s2p_out_buffer.
// Ports   : none (package)
// Macro   : S2P_PARITY_CHECK_EN (consumed by the modules, not here)
package s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  localparam logic   RST_DATA_BIT = 1'b0;
  localparam logic   RST_VALID    = 1'b0;
  localparam logic   RST_OVERRUN  = 1'b0;
  localparam logic   RST_PERR     = 1'b0;
  localparam logic   RST_ORDER    = ORDER_LSB;
  localparam state_e RST_STATE    = S_IDLE;

endpackage

// File: rtl/s2p_out_buffer.sv
// rtl/s2p_out_buffer.sv - one-entry valid/ready output buffer with overrun flag
//
// Purpose : Holds one completed word until the consumer takes it. A word
//           completing while the buffer is full and not being drained is
//           dropped and flags a sticky overrun.
// Macro   : S2P_PARITY_CHECK_EN adds load_perr_i / perr_o.
// Ports   : clk, reset_n          clock, async active-low reset
//           load_i, load_data_i   completed word strobe and value
//           load_perr_i           parity error for that word (macro only)
//           ready_i               consumer ready
//           clear_overrun_i       clears the sticky overrun flag
//           data_o, valid_o       buffered word and its valid flag
//           overrun_o             sticky dropped-word flag
//           perr_o                parity error held with data_o (macro only)
module s2p_out_buffer
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
`ifdef S2P_PARITY_CHECK_EN
  input  logic             load_perr_i,
  output logic             perr_o,
`endif
  input  logic             ready_i,
  input  logic             clear_overrun_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef S2P_PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  // A slot is free if empty or being drained this cycle, which lets a new
  // word replace an accepted one with no bubble.
  logic can_load;
  assign can_load = !valid_q || ready_i;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef S2P_PARITY_CHECK_EN
    perr_d    = perr_q;
`endif
    if (valid_q && ready_i) valid_d = 1'b0;
    if (clear_overrun_i)    overrun_d = 1'b0;
    // Set after clear so a simultaneous new overrun wins.
    if (load_i) begin
      if (can_load) begin
        data_d  = load_data_i;
        valid_d = 1'b1;
`ifdef S2P_PARITY_CHECK_EN
        perr_d  = load_perr_i;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= {WIDTH{RST_DATA_BIT}};
      valid_q   <= RST_VALID;
      overrun_q <= RST_OVERRUN;
`ifdef S2P_PARITY_CHECK_EN
      perr_q    <= RST_PERR;
`endif
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef S2P_PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
`ifdef S2P_PARITY_CHECK_EN
  assign perr_o    = perr_q;
`endif

endmodule

// File: rtl/serial_to_parallel_register.sv
// rtl/serial_to_parallel_register.sv - serial bit stream to WIDTH-bit word assembler
//
// Purpose : Shifts in one bit per accepted cycle (enable && serial_valid &&
//           !sync), assembles WIDTH-bit words in either bit order and hands
//           them to a one-entry valid/ready output buffer.
// Macro   : S2P_PARITY_CHECK_EN adds a trailing even-parity bit per frame and
//           the parity_err output.
// Ports   : clk, reset_n            clock, async active-low reset
//           enable                  global qualifier for the assembly path
//           sync                    frame resync, drops the partial word
//           msb_first               bit order, sampled on a word's first bit
//           serial_in, serial_valid serial bit and its qualifier
//           data_out, data_valid    buffered word and valid flag
//           data_ready              consumer accepts data_out
//           overrun, clear_overrun  sticky dropped-word flag and its clear
//           bit_count               bits accepted in the current word
//           parity_err              parity result for data_out (macro only)
module serial_to_parallel_register
  import s2p_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             msb_first,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clear_overrun,
`ifdef S2P_PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q, order_d;

  logic             word_done;
  logic [WIDTH-1:0] word;
`ifdef S2P_PARITY_CHECK_EN
  logic             word_perr;
`endif

  // The first bit of a word uses the live msb_first since order_q is only
  // being loaded on that same edge.
  logic             shift_order;
  logic [WIDTH-1:0] sr_shifted;
  assign shift_order = (state_q == S_IDLE) ? msb_first : order_q;
  assign sr_shifted  = (shift_order == ORDER_MSB) ? {sr_q[WIDTH-2:0], serial_in}
                                                  : {serial_in, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    order_d   = order_q;
    word_done = 1'b0;
    word      = sr_shifted;
`ifdef S2P_PARITY_CHECK_EN
    word_perr = 1'b0;
`endif
    if (enable) begin
      if (sync) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (serial_valid) begin
        case (state_q)
          S_IDLE: begin
            order_d = msb_first;
            sr_d    = sr_shifted;
            cnt_d   = CNT_W'(1);
            state_d = S_SHIFT;
          end
          S_SHIFT: begin
            sr_d = sr_shifted;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
`ifdef S2P_PARITY_CHECK_EN
              state_d = S_PARITY;
`else
              state_d   = S_IDLE;
              word_done = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef S2P_PARITY_CHECK_EN
          S_PARITY: begin
            // serial_in is the parity bit; the word itself is already in sr_q.
            word      = sr_q;
            word_perr = ^{sr_q, serial_in};
            word_done = 1'b1;
            state_d   = S_IDLE;
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      sr_q    <= {WIDTH{RST_DATA_BIT}};
      cnt_q   <= '0;
      order_q <= RST_ORDER;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

  assign bit_count = cnt_q;

  s2p_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
    .clk             (clk),
    .reset_n         (reset_n),
    .load_i          (word_done),
    .load_data_i     (word),
`ifdef S2P_PARITY_CHECK_EN
    .load_perr_i     (word_perr),
    .perr_o          (parity_err),
`endif
    .ready_i         (data_ready),
    .clear_overrun_i (clear_overrun),
    .data_o          (data_out),
    .valid_o         (data_valid),
    .overrun_o       (overrun)
  );

endmodule

// File: tb/tb_serial_to_parallel_register.sv
// tb/tb_serial_to_parallel_register.sv - scoreboard bench for serial_to_parallel_register
module tb_serial_to_parallel_register;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, sync, msb_first, serial_in, serial_valid;
  logic [7:0] data_out;
  logic       data_valid, data_ready, overrun, clear_overrun;
  logic [3:0] bit_count;
`ifdef S2P_PARITY_CHECK_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  serial_to_parallel_register #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sync          (sync),
    .msb_first     (msb_first),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
`ifdef S2P_PARITY_CHECK_EN
    .parity_err    (parity_err),
`endif
    .bit_count     (bit_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each word the consumer takes is compared with the oldest
  // expected word.
  always @(negedge clk) begin
    if (reset_n && data_valid && data_ready) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check_eq("sb_word", 32'(data_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    step();
    serial_valid = 1'b0;
  endtask

  // Sends the first nbits of w in transmission order for the chosen bit order.
  task automatic send_word(input logic [7:0] w, input logic msb, input int nbits);
    msb_first = msb;
    for (int i = 0; i < nbits; i++) send_bit(msb ? w[7-i] : w[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; sync = 1'b0; msb_first = 1'b1;
    serial_in = 1'b0; serial_valid = 1'b0; data_ready = 1'b1; clear_overrun = 1'b0;
    step();
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_count", 32'(bit_count), 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // MSB-first, consecutive bits
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1, 7);
    check_eq("t1_count7", 32'(bit_count), 32'd7);
    check_eq("t1_not_yet", 32'(data_valid), 32'd0);
    send_bit(1'b1);
    check_eq("t1_valid_rise", 32'(data_valid), 32'd1);
    check_eq("t1_count0", 32'(bit_count), 32'd0);
    step();
    check_eq("t1_valid_fall", 32'(data_valid), 32'd0);

    // LSB-first with a gap after every bit
    sb_q.push_back(8'hA5);
    msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(((8'hA5 >> i) & 8'h1) != 0);
      if (i < 7) check_eq("t2_count", 32'(bit_count), 32'(i + 1));
      step();
      if (i < 7) check_eq("t2_count_gap", 32'(bit_count), 32'(i + 1));
    end

    // Back-to-back, acceptance on the completion cycle of the second word
    data_ready = 1'b0;
    sb_q.push_back(8'h3C);
    sb_q.push_back(8'hC3);
    send_word(8'h3C, 1'b1, 8);
    send_word(8'hC3, 1'b1, 7);
    data_ready = 1'b1;
    send_bit(1'b1);
    check_eq("t3_valid_kept", 32'(data_valid), 32'd1);
    check_eq("t3_data_c3", 32'(data_out), 32'hC3);
    step();
    check_eq("t3_no_overrun", 32'(overrun), 32'd0);

    // Backpressure throughout: second word dropped
    data_ready = 1'b0;
    send_word(8'h3C, 1'b1, 8);
    send_word(8'hC3, 1'b1, 8);
    step();
    check_eq("t4_data_held", 32'(data_out), 32'h3C);
    check_eq("t4_valid", 32'(data_valid), 32'd1);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check_eq("t4_overrun_clr", 32'(overrun), 32'd0);
    // clear and new overrun in the same cycle: overrun wins
    send_word(8'h55, 1'b1, 7);
    clear_overrun = 1'b1;
    send_bit(1'b1);
    clear_overrun = 1'b0;
    check_eq("t4_overrun_prio", 32'(overrun), 32'd1);
    check_eq("t4_data_still", 32'(data_out), 32'h3C);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    sb_q.push_back(8'h3C);
    data_ready = 1'b1;
    step();
    check_eq("t4_drained", 32'(data_valid), 32'd0);

    // Resync after 5 bits; the sync cycle also carries a valid bit
    send_word(8'hD8, 1'b1, 5);
    sync = 1'b1; serial_in = 1'b1; serial_valid = 1'b1;
    step();
    sync = 1'b0; serial_valid = 1'b0;
    check_eq("t5_count0", 32'(bit_count), 32'd0);
    check_eq("t5_no_partial", 32'(data_valid), 32'd0);
    sb_q.push_back(8'hF0);
    send_word(8'hF0, 1'b1, 8);
    check_eq("t5_data_f0", 32'(data_out), 32'hF0);
    step();

    // Async reset mid-word with a word pending
    data_ready = 1'b0;
    send_word(8'h5A, 1'b1, 8);
    send_word(8'h96, 1'b1, 3);
    check_eq("t6_pending", 32'(data_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_data", 32'(data_out), 32'h0);
    check_eq("t6_rst_valid", 32'(data_valid), 32'd0);
    check_eq("t6_rst_count", 32'(bit_count), 32'd0);
    step();
    reset_n = 1'b1;
    data_ready = 1'b1;
    step();
    sb_q.push_back(8'h96);
    send_word(8'h96, 1'b1, 8);
    check_eq("t6_data_96", 32'(data_out), 32'h96);
    step();

`ifdef S2P_PARITY_CHECK_EN
    sb_q.push_back(8'h81);
    send_word(8'h81, 1'b1, 8);
    check_eq("t7_wait_parity", 32'(data_valid), 32'd0);
    send_bit(1'b0);
    check_eq("t7_perr0", 32'(parity_err), 32'd0);
    check_eq("t7_valid0", 32'(data_valid), 32'd1);
    step();
    sb_q.push_back(8'h81);
    send_word(8'h81, 1'b1, 8);
    send_bit(1'b1);
    check_eq("t7_perr1", 32'(parity_err), 32'd1);
    check_eq("t7_valid1", 32'(data_valid), 32'd1);
    step();
`endif

    step();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
